// File: rtl/knn_vote.sv
// knn_vote: majority vote over the K nearest neighbours produced by an
// upstream sorter. Neighbour indices are read one per cycle through SEL,
// their labels are looked up in a local label memory and tallied, and the
// winning class is reported with a one-cycle class_valid pulse.
//
// state  | meaning
// IDLE   | waiting for start, vote counters cleared on start
// READ   | SEL steps 0..K-1, DATA_IN captured into idx[]
// VOTE   | one neighbour per cycle: label looked up and counted
// DECIDE | scan neighbours in order, strict-greater wins, register class_out
// DONE   | class_valid pulse, back to IDLE
module knn_vote #(
  parameter int K     = 4,
  parameter int IDX_W = 8,
  parameter int LBL_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [$clog2(K)-1:0] SEL,
  input  logic [IDX_W-1:0]     DATA_IN,
  input  logic                 label_we,
  input  logic [IDX_W-1:0]     label_addr,
  input  logic [LBL_W-1:0]     label_wdata,
  output logic                 busy,
  output logic                 class_valid,
  output logic [LBL_W-1:0]     class_out
);

  localparam int SEL_W = $clog2(K);
  localparam int CNT_W = $clog2(K + 1);
  localparam int NLBL  = 2 ** LBL_W;
  localparam int DEPTH = 2 ** IDX_W;
  localparam logic [SEL_W-1:0] LAST = SEL_W'(K - 1);

  typedef enum logic [2:0] {IDLE, READ, VOTE, DECIDE, DONE} state_t;

  state_t            state, state_nx;
  logic [SEL_W-1:0]  step;
  logic [LBL_W-1:0]  label_mem [DEPTH];
  logic [IDX_W-1:0]  idx       [K];
  logic [LBL_W-1:0]  lbl       [K];
  logic [CNT_W-1:0]  count     [NLBL];
  logic [LBL_W-1:0]  vote_lbl;
  logic [LBL_W-1:0]  winner;
  logic [CNT_W-1:0]  best_cnt;

  // Combinational read; a same-cycle write lands only at the edge, so the
  // reader sees the old value.
  assign vote_lbl = label_mem[idx[step]];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state and Moore outputs.
  always_comb begin
    state_nx    = state;
    busy        = 1'b1;
    class_valid = 1'b0;
    SEL         = '0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nx = READ;
      end
      READ: begin
        SEL = step;
        if (step == LAST) state_nx = VOTE;
      end
      VOTE: begin
        if (step == LAST) state_nx = DECIDE;
      end
      DECIDE: state_nx = DONE;
      DONE: begin
        class_valid = 1'b1;
        state_nx    = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Neighbour step counter shared by READ and VOTE; wraps on the last one.
  always_ff @(posedge clk) begin
    if (rst) begin
      step <= '0;
    end else if (state == READ || state == VOTE) begin
      step <= (step == LAST) ? '0 : step + SEL_W'(1);
    end else begin
      step <= '0;
    end
  end

  // Label memory: written in any state, never reset.
  always_ff @(posedge clk) begin
    if (label_we) label_mem[label_addr] <= label_wdata;
  end

  // Tie-break scan: strictly greater replaces, so the earliest neighbour of
  // a tied label keeps the win. Uses the labels latched during VOTE so a
  // later label write cannot change the decision after it was counted.
  always_comb begin
    best_cnt = '0;
    winner   = '0;
    for (int j = 0; j < K; j++) begin
      if (count[lbl[j]] > best_cnt) begin
        best_cnt = count[lbl[j]];
        winner   = lbl[j];
      end
    end
  end

  // Capture, tally and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < K; j++) begin
        idx[j] <= '0;
        lbl[j] <= '0;
      end
      for (int l = 0; l < NLBL; l++) count[l] <= '0;
      class_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            for (int l = 0; l < NLBL; l++) count[l] <= '0;
          end
        end
        READ: idx[step] <= DATA_IN;
        VOTE: begin
          lbl[step]       <= vote_lbl;
          count[vote_lbl] <= count[vote_lbl] + CNT_W'(1);
        end
        DECIDE: class_out <= winner;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_knn_vote.sv
// tb_knn_vote: randomized and directed classification runs checked against a
// counting reference model of the vote.
module tb_knn_vote;

  localparam int K = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] SEL;
  logic [7:0] DATA_IN;
  logic       label_we = 1'b0;
  logic [7:0] label_addr = '0;
  logic [3:0] label_wdata = '0;
  logic       busy;
  logic       class_valid;
  logic [3:0] class_out;

  logic [7:0] sorter [K];
  int         lbl_m  [256];
  int         n_vec = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  assign DATA_IN = sorter[SEL];

  knn_vote #(.K(K), .IDX_W(8), .LBL_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .SEL(SEL), .DATA_IN(DATA_IN),
    .label_we(label_we), .label_addr(label_addr), .label_wdata(label_wdata),
    .busy(busy), .class_valid(class_valid), .class_out(class_out)
  );

  task automatic check(input string tag, input int obs, input int expv);
    n_vec++;
    if (obs != expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Majority label; among labels with the top count, the one appearing at the
  // lowest neighbour position wins.
  function automatic int ref_class();
    int cnt [16];
    int top;
    foreach (cnt[l]) cnt[l] = 0;
    for (int j = 0; j < K; j++) cnt[lbl_m[sorter[j]]]++;
    top = 0;
    foreach (cnt[l]) if (cnt[l] > top) top = cnt[l];
    for (int j = 0; j < K; j++)
      if (cnt[lbl_m[sorter[j]]] == top) return lbl_m[sorter[j]];
    return 0;
  endfunction

  task automatic wr(input int a, input int d);
    @(negedge clk);
    label_we = 1'b1; label_addr = 8'(a); label_wdata = 4'(d);
    lbl_m[a] = d;
    @(negedge clk);
    label_we = 1'b0;
  endtask

  task automatic set_sorter(input int a, input int b, input int c, input int d);
    sorter[0] = 8'(a); sorter[1] = 8'(b); sorter[2] = 8'(c); sorter[3] = 8'(d);
  endtask

  // kind: 0 none, 1 start pulse, 2 label write, 3 reset; applied at cycle ac
  // (cycle c is the half-cycle after the c-th edge past the start edge).
  task automatic run_class(input int kind, input int ac, input int aaddr,
                           input int adata, input int expv, input string tag);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 0; c <= 12; c++) begin
      if (c > 0) @(negedge clk);
      if (c == ac + 1) begin
        start = 1'b0; label_we = 1'b0; rst = 1'b0;
      end
      if (kind == 3 && c > ac) begin
        check({tag, ":busy"}, int'(busy), 0);
        check({tag, ":valid"}, int'(class_valid), 0);
        if (c == ac + 1) begin
          check({tag, ":class_out"}, int'(class_out), 0);
          check({tag, ":sel"}, int'(SEL), 0);
        end
      end else begin
        check({tag, ":sel"}, int'(SEL), (c < K) ? c : 0);
        check({tag, ":busy"}, int'(busy), (c <= 2 * K + 1) ? 1 : 0);
        check({tag, ":valid"}, int'(class_valid), (c == 2 * K + 1) ? 1 : 0);
        if (c == 2 * K + 1) check({tag, ":class"}, int'(class_out), expv);
      end
      if (c == ac) begin
        case (kind)
          1: start = 1'b1;
          2: begin
            label_we = 1'b1; label_addr = 8'(aaddr); label_wdata = 4'(adata);
            lbl_m[aaddr] = adata;
          end
          3: rst = 1'b1;
          default: ;
        endcase
      end
    end
  endtask

  initial begin
    set_sorter(0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check("rst:busy", int'(busy), 0);
    check("rst:valid", int'(class_valid), 0);
    check("rst:class_out", int'(class_out), 0);
    check("rst:sel", int'(SEL), 0);
    rst = 1'b0;

    for (int a = 0; a < 256; a++) wr(a, int'($urandom_range(0, 15)));

    // Basic majority.
    wr(10, 3); wr(20, 3); wr(30, 5); wr(40, 3);
    set_sorter(10, 30, 20, 40);
    run_class(0, -1, 0, 0, 3, "basic");

    // Ties resolve to the nearest occurrence.
    wr(1, 1); wr(2, 2); wr(3, 2); wr(4, 1);
    set_sorter(1, 2, 3, 4);
    run_class(0, -1, 0, 0, 1, "tie_a");
    wr(1, 7); wr(4, 7);
    run_class(0, -1, 0, 0, 7, "tie_b");

    // All neighbours identical, then a fresh run from cleared counters.
    wr(55, 9);
    set_sorter(55, 55, 55, 55);
    run_class(0, -1, 0, 0, 9, "dup");
    set_sorter(10, 30, 20, 40);
    run_class(0, -1, 0, 0, 3, "fresh");

    // start during VOTE and during DONE is ignored.
    run_class(1, 5, 0, 0, 3, "start_vote");
    run_class(1, 9, 0, 0, 3, "start_done");

    // Label writes during READ are seen; during the last VOTE cycle are not.
    wr(10, 3); wr(30, 6); wr(20, 6); wr(40, 3);
    run_class(2, 1, 10, 6, 6, "wr_read");
    wr(10, 3);
    run_class(2, 7, 40, 6, 3, "wr_vote");
    run_class(0, -1, 0, 0, 6, "wr_after");

    // Reset mid-VOTE aborts; label memory survives.
    set_sorter(10, 30, 20, 40);
    run_class(3, 5, 0, 0, 0, "rst_vote");
    run_class(0, -1, 0, 0, ref_class(), "post_rst");

    // Randomized runs; small index range forces duplicates and ties.
    for (int it = 0; it < 40; it++) begin
      int hi;
      hi = (it % 2 == 0) ? 7 : 255;
      for (int w = 0; w < 3; w++)
        wr(int'($urandom_range(0, hi)), int'($urandom_range(0, (it % 3 == 0) ? 3 : 15)));
      for (int j = 0; j < K; j++) sorter[j] = 8'($urandom_range(0, hi));
      run_class(0, -1, 0, 0, ref_class(), $sformatf("rnd%0d", it));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
